// File: rtl/down_counter_if.sv
// Bundles the count-control inputs and count/status outputs of down_counter.
interface down_counter_if #(
  parameter int unsigned EXP = 3
);
  logic           CE;
  logic           LOAD;
  logic [EXP-1:0] D;
  logic           ONESHOT;
  logic [EXP-1:0] Q;
  logic           TC;
  logic           DONE;

  modport master (
    output CE, LOAD, D, ONESHOT,
    input  Q, TC, DONE
  );

  modport slave (
    input  CE, LOAD, D, ONESHOT,
    output Q, TC, DONE
  );
endinterface

// File: rtl/down_counter.sv
// Modulo-WIDTH loadable down counter with periodic / one-shot modes and a cascadable borrow.
// Optional reload register enabled by defining DOWN_COUNTER_RELOAD_EN.
module down_counter #(
  parameter int unsigned EXP   = 3,
  parameter int unsigned WIDTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  down_counter_if.slave cnt
);

  if (WIDTH < 1 || (64'd1 << EXP) < 64'(WIDTH)) begin : g_bad_params
    $error("down_counter: WIDTH must be in 1..2**EXP");
  end

  localparam logic [EXP-1:0] MaxVal = EXP'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e         state_q, state_d;
  logic [EXP-1:0] q_q, q_d;
  logic           done_q, done_d;
  logic [EXP-1:0] load_val;
  logic [EXP-1:0] wrap_val;

  // Out-of-range load values clamp to the top count so Q never leaves 0..WIDTH-1.
  assign load_val = (cnt.D > MaxVal) ? MaxVal : cnt.D;

`ifdef DOWN_COUNTER_RELOAD_EN
  logic [EXP-1:0] reload_q, reload_d;

  always_comb begin
    reload_d = reload_q;
    if (cnt.LOAD) begin
      reload_d = load_val;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      reload_q <= MaxVal;
    end else begin
      reload_q <= reload_d;
    end
  end

  assign wrap_val = reload_q;
`else
  assign wrap_val = MaxVal;
`endif

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    if (cnt.LOAD) begin
      q_d     = load_val;
      state_d = StRun;
    end else begin
      case (state_q)
        StRun: begin
          if (cnt.CE) begin
            if (q_q != '0) begin
              q_d = q_q - EXP'(1);
            end else if (cnt.ONESHOT) begin
              state_d = StDone;
            end else begin
              q_d = wrap_val;
            end
          end
        end
        StIdle, StDone: begin
          state_d = state_q;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
    done_d = (state_d == StDone);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= StIdle;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  assign cnt.Q    = q_q;
  assign cnt.DONE = done_q;
  // Borrow is combinational on CE so it can enable a higher-order stage in the same cycle.
  assign cnt.TC   = (state_q == StRun) && (q_q == '0) && cnt.CE;

endmodule

// File: tb/tb_down_counter.sv
// Directed, table-driven checks of down_counter plus hand-written multi-cycle sequences.
module tb_down_counter;

  logic CLK;
  logic RST;

  down_counter_if #(.EXP(3)) if_a ();
  down_counter_if #(.EXP(3)) if_b ();
  down_counter_if #(.EXP(3)) if_lo ();
  down_counter_if #(.EXP(3)) if_hi ();

  down_counter #(.EXP(3), .WIDTH(8)) u_a  (.CLK(CLK), .RST(RST), .cnt(if_a));
  down_counter #(.EXP(3), .WIDTH(6)) u_b  (.CLK(CLK), .RST(RST), .cnt(if_b));
  down_counter #(.EXP(3), .WIDTH(8)) u_lo (.CLK(CLK), .RST(RST), .cnt(if_lo));
  down_counter #(.EXP(3), .WIDTH(8)) u_hi (.CLK(CLK), .RST(RST), .cnt(if_hi));

  assign if_hi.CE = if_lo.TC;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

`ifdef DOWN_COUNTER_RELOAD_EN
  localparam logic [2:0] W5 = 3'd5;
  localparam logic [2:0] W2 = 3'd2;
  localparam int         Tc30 = 2;
`else
  localparam logic [2:0] W5 = 3'd7;
  localparam logic [2:0] W2 = 3'd7;
  localparam int         Tc30 = 1;
`endif
  localparam logic [2:0] W5m1 = W5 - 3'd1;

  typedef struct {
    logic       rst;
    logic       load;
    logic       ce;
    logic [2:0] d;
    logic       os;
    logic       tc;    // expected TC before the edge
    logic [2:0] q;     // expected Q after the edge
    logic       done;  // expected DONE after the edge
  } vec_t;

  localparam int NVec = 28;
  vec_t vecs [NVec];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  logic [2:0] exp30 [8];
  int         tc_cnt;

  initial begin
    //          rst   load  ce    d     os    tc    q     done
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 3'd5, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd4, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd3, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd2, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, W5,   1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, W5m1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 3'd5, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 3'd4, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 3'd3, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 3'd2, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 3'd1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 3'd0, 1'b1};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 3'd2, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 3'd1, 1'b0};
    vecs[21] = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0};
    vecs[22] = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, W2,   1'b0};
    vecs[23] = '{1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 3'd4, 1'b0};
    vecs[24] = '{1'b1, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 3'd6, 1'b0};
    vecs[25] = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd5, 1'b0};
    vecs[26] = '{1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 3'd0, 1'b0};
    vecs[27] = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0};

`ifdef DOWN_COUNTER_RELOAD_EN
    exp30 = '{3'd2, 3'd1, 3'd0, 3'd3, 3'd2, 3'd1, 3'd0, 3'd3};
`else
    exp30 = '{3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3};
`endif

    RST = 1'b0;
    if_a.CE = 1'b0;  if_a.LOAD = 1'b0;  if_a.D = '0;  if_a.ONESHOT = 1'b0;
    if_b.CE = 1'b0;  if_b.LOAD = 1'b0;  if_b.D = '0;  if_b.ONESHOT = 1'b0;
    if_lo.CE = 1'b0; if_lo.LOAD = 1'b0; if_lo.D = '0; if_lo.ONESHOT = 1'b0;
    if_hi.LOAD = 1'b0; if_hi.D = '0; if_hi.ONESHOT = 1'b0;
    step();
    check("reset q", 32'(if_a.Q), 32'd0);
    check("reset done", 32'(if_a.DONE), 32'd0);
    check("reset tc", 32'(if_a.TC), 32'd0);
    RST = 1'b1;

    // Periodic and one-shot counting, load priority and reset override on the WIDTH=8 stage.
    for (int i = 0; i < NVec; i++) begin
      RST          = vecs[i].rst;
      if_a.LOAD    = vecs[i].load;
      if_a.CE      = vecs[i].ce;
      if_a.D       = vecs[i].d;
      if_a.ONESHOT = vecs[i].os;
      #1;
      check($sformatf("v%0d tc", i), 32'(if_a.TC), 32'(vecs[i].tc));
      step();
      check($sformatf("v%0d q", i), 32'(if_a.Q), 32'(vecs[i].q));
      check($sformatf("v%0d done", i), 32'(if_a.DONE), 32'(vecs[i].done));
    end
    RST = 1'b1;
    if_a.CE = 1'b0;
    if_a.LOAD = 1'b0;

    // WIDTH=6: clamped load and wrap to 5.
    if_b.LOAD = 1'b1; if_b.D = 3'd7;
    step();
    check("w6 clamp 7", 32'(if_b.Q), 32'd5);
    if_b.LOAD = 1'b0; if_b.CE = 1'b1;
    for (int v = 4; v >= 0; v--) begin
      check($sformatf("w6 tc q%0d", v + 1), 32'(if_b.TC), 32'd0);
      step();
      check($sformatf("w6 q%0d", v), 32'(if_b.Q), 32'(v));
    end
    check("w6 tc at 0", 32'(if_b.TC), 32'd1);
    step();
    check("w6 wrap", 32'(if_b.Q), 32'd5);
    if_b.CE = 1'b0; if_b.LOAD = 1'b1; if_b.D = 3'd6;
    step();
    check("w6 clamp 6", 32'(if_b.Q), 32'd5);
    if_b.D = 3'd4;
    step();
    check("w6 load 4", 32'(if_b.Q), 32'd4);
    if_b.LOAD = 1'b0;

    // Load 3, periodic, continuous CE: wrap target depends on the reload option.
    if_a.LOAD = 1'b1; if_a.D = 3'd3; if_a.ONESHOT = 1'b0; if_a.CE = 1'b1;
    step();
    check("r30 load", 32'(if_a.Q), 32'd3);
    if_a.LOAD = 1'b0;
    tc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (if_a.TC === 1'b1) tc_cnt++;
      step();
      check($sformatf("r30 q%0d", i), 32'(if_a.Q), 32'(exp30[i]));
    end
    check("r30 tc pulses", 32'(tc_cnt), 32'(Tc30));
    if_a.CE = 1'b0;

    // Cascade: high stage steps once per 8 low-stage CE cycles.
    if_lo.LOAD = 1'b1; if_lo.D = 3'd7;
    if_hi.LOAD = 1'b1; if_hi.D = 3'd7;
    step();
    check("casc lo load", 32'(if_lo.Q), 32'd7);
    check("casc hi load", 32'(if_hi.Q), 32'd7);
    if_lo.LOAD = 1'b0; if_hi.LOAD = 1'b0; if_lo.CE = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k == 7) check("casc hi hold", 32'(if_hi.Q), 32'd7);
      if (k % 8 == 0) begin
        check($sformatf("casc hi k%0d", k), 32'(if_hi.Q), 32'(7 - k / 8));
        check($sformatf("casc lo k%0d", k), 32'(if_lo.Q), 32'd7);
      end
    end
    if_lo.CE = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
